// File: rtl/blft_win_sched.sv
// blft_win_sched: sequencing controller for the bilateral-filter datapath.
//
// Walks the image in raster order. For every pixel it reads the 3x3
// neighbourhood from image memory (border pixels replicated), hands the
// assembled window to the filter core over a valid/ready handshake, waits
// for the core's result and emits it tagged with its raster address.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   start               one-cycle pulse, starts a frame from IDLE or DONE
//   mem_ren/mem_raddr   image memory read request (row*IMG_W+col)
//   mem_rdata           read data, valid one cycle after mem_ren
//   win_valid/win_ready window handshake to the filter core
//   win_data            9 taps, tap k at [8k+7:8k], centre is k=4
//   res_valid/res_data  one-cycle result pulse from the core
//   out_valid/out_addr/out_data  result pixel, one-cycle pulse
//   finish              frame complete, held until the next start
//   busy                high outside IDLE/DONE
module blft_win_sched #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [7:0]        mem_rdata,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [71:0]       win_data,
    input  logic              res_valid,
    input  logic [7:0]        res_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_data,
    output logic              finish,
    output logic              busy
);

    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [RW-1:0]     ROW_ZERO  = RW'(0);
    localparam logic [RW-1:0]     ROW_ONE   = RW'(1);
    localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0]     COL_ZERO  = CW'(0);
    localparam logic [CW-1:0]     COL_ONE   = CW'(1);
    localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(IMG_W);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_RESULT = 3'd4,
        ST_EMIT   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t            state_r, state_s;
    logic [RW-1:0]     row_r, row_s;
    logic [CW-1:0]     col_r, col_s;
    logic [3:0]        tap_r, tap_s;

    logic              cap_vld_r;
    logic [3:0]        cap_k_r;
    logic [71:0]       win_data_r;

    logic              mem_ren_r;
    logic [ADDR_W-1:0] mem_raddr_r;
    logic              win_valid_r;
    logic              out_valid_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic [7:0]        out_data_r;
    logic              finish_r;
    logic              busy_r;

    // Row of tap t: taps 0..2 look one row up, 6..8 one row down, clamped
    // to the image so a border pixel replicates itself instead of wrapping.
    function automatic logic [RW-1:0] clamp_row(input logic [RW-1:0] r, input logic [3:0] t);
        logic [RW-1:0] v;
        v = r;
        case (t)
            4'd0, 4'd1, 4'd2: v = (r == ROW_ZERO) ? r : (r - ROW_ONE);
            4'd6, 4'd7, 4'd8: v = (r == ROW_LAST) ? r : (r + ROW_ONE);
            default:          v = r;
        endcase
        return v;
    endfunction

    // Column of tap t: taps 0,3,6 look left, 2,5,8 look right, clamped so
    // the left/right edge never reaches into the neighbouring row.
    function automatic logic [CW-1:0] clamp_col(input logic [CW-1:0] c, input logic [3:0] t);
        logic [CW-1:0] v;
        v = c;
        case (t)
            4'd0, 4'd3, 4'd6: v = (c == COL_ZERO) ? c : (c - COL_ONE);
            4'd2, 4'd5, 4'd8: v = (c == COL_LAST) ? c : (c + COL_ONE);
            default:          v = c;
        endcase
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] raster(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return (ADDR_W'(r) * WIDTH_A) + ADDR_W'(c);
    endfunction

    // Next-state and counter logic.
    always_comb begin
        state_s = state_r;
        row_s   = row_r;
        col_s   = col_r;
        tap_s   = tap_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_FETCH;
                    row_s   = ROW_ZERO;
                    col_s   = COL_ZERO;
                    tap_s   = 4'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                if (tap_r == 4'd8) begin
                    state_s = ST_WAIT;
                    tap_s   = 4'd0;
                end else begin
                    tap_s   = tap_r + 4'd1;
                end
            end
            ST_WAIT: state_s = ST_ISSUE;
            ST_ISSUE: begin
                if (win_ready) begin
                    state_s = ST_RESULT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_RESULT: begin
                if (res_valid) begin
                    state_s = ST_EMIT;
                end else begin
                    state_s = ST_RESULT;
                end
            end
            ST_EMIT: begin
                if (col_r == COL_LAST) begin
                    col_s = COL_ZERO;
                    if (row_r == ROW_LAST) begin
                        state_s = ST_DONE;
                        row_s   = ROW_ZERO;
                    end else begin
                        state_s = ST_FETCH;
                        row_s   = row_r + ROW_ONE;
                    end
                end else begin
                    state_s = ST_FETCH;
                    col_s   = col_r + COL_ONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and position counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            row_r   <= ROW_ZERO;
            col_r   <= COL_ZERO;
            tap_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            row_r   <= row_s;
            col_r   <= col_s;
            tap_r   <= tap_s;
        end
    end

    // Window assembly: the read for tap k returns one cycle later, so the
    // tap index is delayed alongside a capture strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_vld_r  <= 1'b0;
            cap_k_r    <= 4'd0;
            win_data_r <= 72'd0;
        end else begin
            cap_vld_r <= (state_r == ST_FETCH);
            cap_k_r   <= tap_r;
            if (cap_vld_r) begin
                win_data_r[8*cap_k_r +: 8] <= mem_rdata;
            end
        end
    end

    // Registered outputs, decoded from the next state so they line up
    // with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ren_r   <= 1'b0;
            mem_raddr_r <= ADDR_ZERO;
            win_valid_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_addr_r  <= ADDR_ZERO;
            out_data_r  <= 8'd0;
            finish_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            mem_ren_r   <= (state_s == ST_FETCH);
            mem_raddr_r <= (state_s == ST_FETCH)
                         ? raster(clamp_row(row_s, tap_s), clamp_col(col_s, tap_s))
                         : ADDR_ZERO;
            win_valid_r <= (state_s == ST_ISSUE);
            out_valid_r <= (state_s == ST_EMIT);
            finish_r    <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            if ((state_r == ST_RESULT) && res_valid) begin
                out_addr_r <= raster(row_r, col_r);
                out_data_r <= res_data;
            end
        end
    end

    assign mem_ren   = mem_ren_r;
    assign mem_raddr = mem_raddr_r;
    assign win_valid = win_valid_r;
    assign win_data  = win_data_r;
    assign out_valid = out_valid_r;
    assign out_addr  = out_addr_r;
    assign out_data  = out_data_r;
    assign finish    = finish_r;
    assign busy      = busy_r;

endmodule

// File: doc/blft_win_sched.md
Name: blft_win_sched

Overview:
- Sequencing controller for the bilateral-filter datapath.
- Walks the image in raster order and fetches each pixel's 3x3 neighbourhood from image memory, replicating at the borders.
- Hands the assembled window to the filter core over a valid/ready handshake, then waits for the core's result.
- Tags the result with its raster address and emits it on the out_valid/out_addr/out_data interface. Raises finish after the last pixel.

Parameters:
- IMG_W, 256, image width in pixels (≥2)
- IMG_H, 256, image height in pixels (≥2)
- ADDR_W, 16, address width; IMG_W*IMG_H ≤ 2^ADDR_W

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; starts a frame when idle or done
- mem_ren  output  1  image memory read enable
- mem_raddr  output  ADDR_W  image memory read address (row*IMG_W+col)
- mem_rdata  input  8  read data; valid exactly 1 cycle after mem_ren
- win_valid  output  1  window valid to filter core
- win_ready  input  1  filter core accepts window
- win_data  output  72  tap k at bits [8k+7:8k], k=(dr+1)*3+(dc+1); centre is k=4
- res_valid  input  1  core result valid, 1-cycle pulse
- res_data  input  8  core result
- out_valid  output  1  result pixel valid, 1-cycle pulse
- out_addr  output  ADDR_W  raster address of result pixel
- out_data  output  8  result pixel
- finish  output  1  frame complete; held high until next start
- busy  output  1  high in any state other than IDLE/DONE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; row=col=tap=0.
  - All outputs 0; win_data=0.
- States and transitions:
  - IDLE: on start -> FETCH; clears row, col, tap and finish.
  - FETCH: 9 cycles, tap 0..8. mem_ren=1 and mem_raddr=clampR(row+dr)*IMG_W+clampC(col+dc), with dr=tap/3-1 and dc=tap%3-1. clampR limits to [0,IMG_H-1]; clampC limits to [0,IMG_W-1]. After tap 8 -> WAIT.
  - Window capture: mem_rdata is captured into window slot k on the cycle after the read for tap k is issued.
  - WAIT: 1 cycle; captures tap 8; mem_ren=0 -> ISSUE.
  - ISSUE: win_valid=1 and win_data held stable until win_ready=1 is sampled. Handshake cycle -> RESULT. win_valid drops the next cycle.
  - RESULT: waits for res_valid. Registers out_addr=row*IMG_W+col and out_data=res_data -> EMIT.
  - EMIT: out_valid=1 for exactly one cycle. Advance: col+1; at IMG_W-1, col wraps to 0 and row+1. If the emitted pixel was (IMG_H-1, IMG_W-1) -> DONE, else -> FETCH.
  - DONE: finish=1; on start -> FETCH with row=col=0 and finish cleared in that cycle.
- Handshake and input rules:
  - res_valid outside RESULT is ignored.
  - start outside IDLE/DONE is ignored.
  - win_ready outside ISSUE is ignored.
- Throughput: one window in flight. Minimum 13 cycles per pixel (9+1+1+1+1) when win_ready=1 and res_valid arrives 1 cycle after the handshake.
- Address arithmetic:
  - Unsigned, ADDR_W bits. Row and col counters sized clog2(IMG_H) and clog2(IMG_W).
  - Clamping is done on signed row/col±1 before multiplication; no wrap-around into adjacent rows.
- Reset mid-frame: immediately returns to IDLE with all outputs 0. The pending window and any late res_valid are discarded.

Test Plan:
- Corner fetch: IMG_W=IMG_H=4, mem[a]=a, start, win_ready=1 -> mem_raddr taps 0,0,1,0,0,1,4,4,5; win_data bytes (k0..k8)=00,00,01,00,00,01,04,04,05.
- Last-pixel clamp: pixel (3,3) on 4x4 -> mem_raddr 10,11,11,14,15,15,14,15,15; result emits out_addr=15, then finish=1 held; out_valid total count=16.
- Backpressure: win_ready low 5 cycles in ISSUE -> win_valid and win_data stable throughout; handshake on 6th cycle; no extra mem_ren.
- Result tagging: core returns res_data=~centre after 3 cycles -> each out_valid pulse has out_addr=raster index, out_data=~out_addr[7:0], addresses strictly increasing 0..15.
- Reset mid-frame: rst=0 during FETCH of pixel 5 -> same cycle all outputs 0, busy=0. A new start restarts at out_addr=0 and completes 16 pixels.
- Ignored events: start while busy, plus res_valid during FETCH -> no restart, no spurious out_valid; 13-cycle per-pixel timing unchanged.
